regfile_ctx_scheduler: RTL

//  Barrel-style hardware-context scheduler for the 5-bank register-file repository.

---
 rtl/regfile_ctx_scheduler.sv | 88 ++++++++
 1 files changed

// File: rtl/regfile_ctx_scheduler.sv
// Barrel context scheduler: round-robin issue of ready contexts, with a shadow tag
// pipeline that steers the register-file bank write select and write enable at writeback.
module regfile_ctx_scheduler #(
    parameter int NCTX   = 5,
    parameter int CTX_W  = 3,
    parameter int WB_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCTX-1:0]  ctx_ready,
    input  logic [NCTX-1:0]  ctx_kill,
    input  logic             stall,
    input  logic             wb_we,
    output logic             issue_valid,
    output logic [CTX_W-1:0] issue_ctx,
    output logic [CTX_W-1:0] rf_sel_wr,
    output logic             rf_we,
    output logic [31:0]      idle_cnt
);

    logic [WB_LAT:0]            pipe_v;
    logic [WB_LAT:0][CTX_W-1:0] pipe_tag;
    logic [CTX_W-1:0]           last_grant;
    logic [CTX_W-1:0]           grant;
    logic                       any_eligible;
    logic [NCTX-1:0]            inflight;
    logic [NCTX-1:0]            eligible;

    function automatic logic tag_killed(input logic [CTX_W-1:0] tag,
                                        input logic [NCTX-1:0]  kill);
        tag_killed = 1'b0;
        for (int c = 0; c < NCTX; c++)
            if (tag == CTX_W'(c)) tag_killed = kill[c];
    endfunction

    // A context is busy from issue until its entry leaves the writeback stage
    always_comb begin
        inflight = '0;
        for (int s = 0; s <= WB_LAT; s++)
            for (int c = 0; c < NCTX; c++)
                if (pipe_v[s] && pipe_tag[s] == CTX_W'(c)) inflight[c] = 1'b1;
    end

    assign eligible = ctx_ready & ~inflight & ~ctx_kill;

    // Scan downward so the nearest context after last_grant is the final winner
    always_comb begin
        int idx;
        idx          = 0;
        grant        = '0;
        any_eligible = 1'b0;
        for (int k = NCTX; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NCTX;
            if (eligible[idx]) begin
                grant        = CTX_W'(idx);
                any_eligible = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v     <= '0;
            pipe_tag   <= '0;
            last_grant <= CTX_W'(NCTX - 1);
            idle_cnt   <= '0;
        end else if (!stall) begin
            for (int s = WB_LAT; s >= 1; s--) begin
                pipe_v[s]   <= pipe_v[s-1] & ~tag_killed(pipe_tag[s-1], ctx_kill);
                pipe_tag[s] <= pipe_tag[s-1];
            end
            pipe_v[0]   <= any_eligible;
            pipe_tag[0] <= grant;
            if (any_eligible) last_grant <= grant;
            if (!any_eligible && idle_cnt != 32'hFFFF_FFFF) idle_cnt <= idle_cnt + 32'd1;
        end else begin
            for (int s = 0; s <= WB_LAT; s++)
                pipe_v[s] <= pipe_v[s] & ~tag_killed(pipe_tag[s], ctx_kill);
        end
    end

    assign issue_valid = pipe_v[0];
    assign issue_ctx   = pipe_tag[0];
    assign rf_sel_wr   = pipe_tag[WB_LAT];
    assign rf_we       = pipe_v[WB_LAT] & wb_we & ~stall
                         & ~tag_killed(pipe_tag[WB_LAT], ctx_kill) & ~rst;

endmodule
